// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 character LCD controller:
// state encodings, command bytes and the init command table.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT,
        IDLE,
        ADDR1,
        LINE1,
        ADDR2,
        LINE2
    } state_t;

    typedef enum logic [1:0] {
        B_IDLE,
        B_SETUP,
        B_EN,
        B_WAIT
    } bus_state_t;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_LINE1    = 8'h80;
    localparam logic [7:0] CMD_LINE2    = 8'hC0;

    function automatic logic [7:0] init_cmd(input logic [1:0] step);
        logic [7:0] c;
        case (step)
            2'd0:    c = CMD_FUNC_SET;
            2'd1:    c = CMD_DISP_ON;
            2'd2:    c = CMD_ENTRY;
            default: c = CMD_CLEAR;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lcd_bus_write.sv
// One HD44780 write: setup cycle, T_EN enable-high cycles, then a
// post-strobe wait. A new start is accepted in the last wait cycle.
module lcd_bus_write
    import lcd_pkg::*;
#(
    parameter int T_EN  = 25,
    parameter int T_CMD = 2500,
    parameter int T_CLR = 100000,
    parameter int CW    = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic       long_wait,
    output logic       ready,
    output logic       done,
    output logic       lcd_rs,
    output logic       lcd_e,
    output logic [7:0] lcd_data
);

    localparam logic [CW-1:0] EN_LAST  = CW'(T_EN - 1);
    localparam logic [CW-1:0] CMD_LAST = CW'(T_CMD - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(T_CLR - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    bus_state_t    state;
    bus_state_t    next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          long_q;
    logic [CW-1:0] wait_last;

    assign wait_last = long_q ? CLR_LAST : CMD_LAST;
    assign done      = (state == B_WAIT) && (cnt == wait_last);
    assign ready     = (state == B_IDLE) || done;

    // Phase sequencing; a pending start chains straight into a new setup.
    always_comb begin
        next  = state;
        cnt_n = '0;
        unique case (state)
            B_IDLE: begin
                if (start) next = B_SETUP;
            end
            B_SETUP: begin
                next = B_EN;
            end
            B_EN: begin
                if (cnt == EN_LAST) next = B_WAIT;
                else cnt_n = cnt + ONE;
            end
            B_WAIT: begin
                if (done) next = start ? B_SETUP : B_IDLE;
                else cnt_n = cnt + ONE;
            end
            default: next = B_IDLE;
        endcase
    end

    // Registered phase, counter and bus pins; rs/data only move on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= B_IDLE;
            cnt      <= '0;
            long_q   <= 1'b0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
        end else begin
            state <= next;
            cnt   <= cnt_n;
            lcd_e <= (next == B_EN);
            if (ready && start) begin
                lcd_rs   <= rs;
                lcd_data <= data;
                long_q   <= long_wait;
            end
        end
    end

endmodule

// File: rtl/lcd_controller.sv
// HD44780 2x16 controller: power-up wait, init sequence, then
// redraws a snapshot of the 32-char message on each refresh.
module lcd_controller
    import lcd_pkg::*;
#(
    parameter int T_PWR = 750000,
    parameter int T_EN  = 25,
    parameter int T_CMD = 2500,
    parameter int T_CLR = 100000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] message,
    input  logic         refresh,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic         lcd_e,
    output logic [7:0]   lcd_data,
    output logic         busy,
    output logic         frame_done
);

    localparam int M1   = (T_PWR > T_CLR) ? T_PWR : T_CLR;
    localparam int M2   = (T_EN > T_CMD) ? T_EN : T_CMD;
    localparam int MAXW = (M1 > M2) ? M1 : M2;
    localparam int CW   = $clog2(MAXW + 1);

    localparam logic [CW-1:0] PWR_LAST = CW'(T_PWR - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    state_t        state;
    state_t        next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [1:0]    step;
    logic [1:0]    step_n;
    logic [4:0]    idx;
    logic [4:0]    idx_n;
    logic          drain;
    logic          drain_n;
    logic          pending;
    logic [255:0]  frame;
    logic          load;

    logic          start;
    logic          wr_rs;
    logic [7:0]    wr_data;
    logic          long_wait;
    logic          ready;
    logic          done;
    logic [7:0]    cur_char;

    assign cur_char  = frame[{idx, 3'b000} +: 8];
    assign long_wait = !wr_rs && (wr_data == CMD_CLEAR);
    assign busy      = (state != IDLE);
    assign lcd_rw    = 1'b0;

    // Sequencer: picks the next byte to offer and advances on accept;
    // drain waits for the final write of INIT/LINE2 to finish.
    always_comb begin
        next       = state;
        cnt_n      = cnt;
        step_n     = step;
        idx_n      = idx;
        drain_n    = drain;
        load       = 1'b0;
        start      = 1'b0;
        wr_rs      = 1'b0;
        wr_data    = 8'h00;
        frame_done = 1'b0;
        unique case (state)
            PWR_WAIT: begin
                if (cnt == PWR_LAST) begin
                    next  = INIT;
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            INIT: begin
                if (!drain) begin
                    start   = 1'b1;
                    wr_data = init_cmd(step);
                    if (ready) begin
                        if (step == 2'd3) drain_n = 1'b1;
                        else step_n = step + 2'd1;
                    end
                end else if (done) begin
                    next    = IDLE;
                    drain_n = 1'b0;
                    step_n  = 2'd0;
                end
            end
            IDLE: begin
                if (refresh || pending) begin
                    next = ADDR1;
                    load = 1'b1;
                end
            end
            ADDR1: begin
                start   = 1'b1;
                wr_data = CMD_LINE1;
                if (ready) begin
                    next  = LINE1;
                    idx_n = 5'd0;
                end
            end
            LINE1: begin
                start   = 1'b1;
                wr_rs   = 1'b1;
                wr_data = cur_char;
                if (ready) begin
                    if (idx == 5'd15) next = ADDR2;
                    idx_n = idx + 5'd1;
                end
            end
            ADDR2: begin
                start   = 1'b1;
                wr_data = CMD_LINE2;
                if (ready) next = LINE2;
            end
            LINE2: begin
                if (!drain) begin
                    start   = 1'b1;
                    wr_rs   = 1'b1;
                    wr_data = cur_char;
                    if (ready) begin
                        if (idx == 5'd31) drain_n = 1'b1;
                        else idx_n = idx + 5'd1;
                    end
                end else if (done) begin
                    frame_done = 1'b1;
                    next       = IDLE;
                    drain_n    = 1'b0;
                    idx_n      = 5'd0;
                end
            end
            default: next = PWR_WAIT;
        endcase
    end

    // State, counters, snapshot and the one-deep pending redraw flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= PWR_WAIT;
            cnt     <= '0;
            step    <= 2'd0;
            idx     <= 5'd0;
            drain   <= 1'b0;
            pending <= 1'b0;
            frame   <= '0;
        end else begin
            state <= next;
            cnt   <= cnt_n;
            step  <= step_n;
            idx   <= idx_n;
            drain <= drain_n;
            if (load) begin
                frame   <= message;
                pending <= 1'b0;
            end else if (refresh && state != IDLE) begin
                pending <= 1'b1;
            end
        end
    end

    lcd_bus_write #(
        .T_EN  (T_EN),
        .T_CMD (T_CMD),
        .T_CLR (T_CLR),
        .CW    (CW)
    ) u_bus (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rs        (wr_rs),
        .data      (wr_data),
        .long_wait (long_wait),
        .ready     (ready),
        .done      (done),
        .lcd_rs    (lcd_rs),
        .lcd_e     (lcd_e),
        .lcd_data  (lcd_data)
    );

endmodule

// File: tb/tb_lcd_controller.sv
// Bench for lcd_controller: timeline model of expected strobes,
// busy and frame_done, plus directed literal expectations.
module tb_lcd_controller;

    localparam int T_PWR = 10;
    localparam int T_EN  = 2;
    localparam int T_CMD = 4;
    localparam int T_CLR = 8;
    localparam int TX    = 1 + T_EN + T_CMD;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         refresh = 1'b0;
    logic [255:0] message = '0;
    logic         lcd_rs;
    logic         lcd_rw;
    logic         lcd_e;
    logic [7:0]   lcd_data;
    logic         busy;
    logic         frame_done;

    lcd_controller #(
        .T_PWR (T_PWR),
        .T_EN  (T_EN),
        .T_CMD (T_CMD),
        .T_CLR (T_CLR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .message    (message),
        .refresh    (refresh),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_e      (lcd_e),
        .lcd_data   (lcd_data),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         per;
        logic       rs;
        logic [7:0] data;
    } tx_t;

    int  checks   = 0;
    int  failures = 0;
    tx_t exp_q[$];
    tx_t log_q[$];
    int  per       = 0;
    int  idle_from = 0;
    int  fd_per    = -1;
    bit  pend      = 1'b0;
    int  fd_count  = 0;
    int  last_rise = -100;
    logic       cur_rs   = 1'b0;
    logic [7:0] cur_data = 8'h00;
    logic       prev_e   = 1'b0;
    logic       prev_rs  = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h (period %0d)",
                     name, act, req, per);
        end
    endtask

    task automatic push_tx(input int p, input logic rs, input logic [7:0] d);
        tx_t t;
        t.per  = p;
        t.rs   = rs;
        t.data = d;
        exp_q.push_back(t);
    endtask

    // After reset: four init writes, the last one (clear) with a long wait.
    task automatic push_init();
        int r;
        logic [7:0] cmds [4];
        cmds = '{8'h38, 8'h0C, 8'h06, 8'h01};
        r = T_PWR + 2;
        for (int i = 0; i < 4; i++) begin
            push_tx(r + i * TX, 1'b0, cmds[i]);
        end
        idle_from = r + 3 * TX + T_EN + T_CLR;
    endtask

    // Frame snapshotted at edge n: 34 back-to-back writes starting n+2.
    task automatic push_frame(input int n, input logic [255:0] snap);
        int r;
        r = n + 2;
        push_tx(r, 1'b0, 8'h80);
        r += TX;
        for (int k = 0; k < 32; k++) begin
            if (k == 16) begin
                push_tx(r, 1'b0, 8'hC0);
                r += TX;
            end
            push_tx(r, 1'b1, snap[8*k +: 8]);
            r += TX;
        end
        fd_per    = n + 34 * TX;
        idle_from = fd_per + 1;
    endtask

    // Model update on each edge, then per-period output comparison.
    always begin
        bit exp_rise;
        bit exp_e;
        tx_t t;
        @(posedge clk);
        if (rst) begin
            per = 0;
            exp_q.delete();
            pend = 1'b0;
            fd_per = -1;
            last_rise = -100;
            push_init();
        end else begin
            per++;
            if (per - 1 >= idle_from) begin
                if (refresh || pend) begin
                    push_frame(per, message);
                    pend = 1'b0;
                end
            end else if (refresh) begin
                pend = 1'b1;
            end
        end
        #1;
        while (exp_q.size() > 0 && exp_q[0].per < per) void'(exp_q.pop_front());
        exp_rise = (exp_q.size() > 0) && (exp_q[0].per == per);
        if (exp_rise) begin
            t = exp_q.pop_front();
            last_rise = per;
            cur_rs = t.rs;
            cur_data = t.data;
        end
        exp_e = (per >= last_rise) && (per < last_rise + T_EN);
        check("lcd_e", 64'(lcd_e), 64'(exp_e));
        check("busy", 64'(busy), 64'(per < idle_from));
        check("frame_done", 64'(frame_done), 64'(per == fd_per));
        check("lcd_rw", 64'(lcd_rw), 64'(0));
        if (exp_e) begin
            check("lcd_rs", 64'(lcd_rs), 64'(cur_rs));
            check("lcd_data", 64'(lcd_data), 64'(cur_data));
        end
        if (exp_rise) begin
            check("setup_rs", 64'(prev_rs), 64'(cur_rs));
            check("setup_data", 64'(prev_data), 64'(cur_data));
        end
        if (lcd_e && !prev_e) begin
            t.per = per;
            t.rs = lcd_rs;
            t.data = lcd_data;
            log_q.push_back(t);
        end
        if (frame_done) fd_count++;
        prev_e = lcd_e;
        prev_rs = lcd_rs;
        prev_data = lcd_data;
    end

    function automatic logic [8:0] log_at(input int i);
        if (i < log_q.size()) return {log_q[i].rs, log_q[i].data};
        return 9'bx;
    endfunction

    function automatic int log_per(input int i);
        if (i < log_q.size()) return log_q[i].per;
        return -1;
    endfunction

    task automatic set_msg(input string s);
        for (int k = 0; k < 32; k++) message[8*k +: 8] = s[k];
    endtask

    task automatic wait_idle(input string name, input int lim, output int p);
        p = -1;
        for (int i = 0; i < lim; i++) begin
            @(posedge clk);
            #2;
            if (!busy) begin
                p = per;
                break;
            end
        end
        if (p < 0) begin
            checks++;
            failures++;
            $display("FAIL %s: no idle within %0d cycles", name, lim);
        end
    endtask

    task automatic wait_fd(input string name, input int lim, output int p);
        p = -1;
        for (int i = 0; i < lim; i++) begin
            @(posedge clk);
            #2;
            if (frame_done) begin
                p = per;
                break;
            end
        end
        if (p < 0) begin
            checks++;
            failures++;
            $display("FAIL %s: no frame_done within %0d cycles", name, lim);
        end
    endtask

    task automatic pulse_refresh(output int p);
        @(negedge clk);
        refresh = 1'b1;
        @(posedge clk);
        #2;
        p = per;
        @(negedge clk);
        refresh = 1'b0;
    endtask

    initial begin
        int ip;
        int rp;
        int fp;
        int fp2;
        int base;
        int init_per [4];
        logic [8:0] init_dat [4];
        init_per = '{12, 19, 26, 33};
        init_dat = '{9'h038, 9'h00C, 9'h006, 9'h001};

        // Reset values and the power-up/init timeline.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_e", 64'(lcd_e), 64'(0));
        check("rst_rs", 64'(lcd_rs), 64'(0));
        check("rst_data", 64'(lcd_data), 64'(0));
        check("rst_busy", 64'(busy), 64'(1));
        check("rst_fd", 64'(frame_done), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        wait_idle("init_idle", 200, ip);
        check("busy_fall", 64'(ip), 64'(43));
        check("init_count", 64'(log_q.size()), 64'(4));
        for (int i = 0; i < 4; i++) begin
            check("init_rise", 64'(log_per(i)), 64'(init_per[i]));
            check("init_cmd", 64'(log_at(i)), 64'(init_dat[i]));
        end

        // Single frame; message overwritten with 'X' partway through LINE1.
        set_msg("NS:0012 SN:0003 LCD LINE TWO OK!");
        log_q.delete();
        pulse_refresh(rp);
        repeat (40) @(negedge clk);
        message = {32{8'h58}};
        wait_fd("frame1_fd", 400, fp);
        check("frame_latency", 64'(fp - rp), 64'(238));
        check("frame_count", 64'(log_q.size()), 64'(34));
        check("f1_addr1", 64'(log_at(0)), 64'(9'h080));
        check("f1_char0", 64'(log_at(1)), 64'(9'h14E));
        check("f1_char1", 64'(log_at(2)), 64'(9'h153));
        check("f1_char15", 64'(log_at(16)), 64'(9'h120));
        check("f1_addr2", 64'(log_at(17)), 64'(9'h0C0));
        check("f1_char16", 64'(log_at(18)), 64'(9'h14C));
        check("f1_char31", 64'(log_at(33)), 64'(9'h121));
        wait_idle("frame1_idle", 20, ip);

        // Three refreshes inside one frame collapse into one more frame.
        log_q.delete();
        base = fd_count;
        pulse_refresh(rp);
        repeat (20) @(negedge clk);
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        repeat (50) @(negedge clk);
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        repeat (100) @(negedge clk);
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        repeat (800) @(posedge clk);
        #2;
        check("collapse_frames", 64'(fd_count - base), 64'(2));
        check("collapse_idle", 64'(busy), 64'(0));
        check("collapse_tx", 64'(log_q.size()), 64'(68));
        check("collapse_x0", 64'(log_at(1)), 64'(9'h158));
        check("collapse_x1", 64'(log_at(35)), 64'(9'h158));

        // Refresh in the frame_done cycle starts the next frame.
        set_msg("ABCDEFGHIJKLMNOPabcdefghijklmnop");
        pulse_refresh(rp);
        for (int i = 0; i < 400 && per < rp + 238; i++) begin
            @(posedge clk);
            #2;
        end
        @(negedge clk);
        check("fd_coincident", 64'(frame_done), 64'(1));
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        wait_fd("frame2_fd", 400, fp2);
        check("back_to_back", 64'(fp2 - (rp + 238)), 64'(240));
        wait_idle("frame2_idle", 20, ip);

        // Reset while lcd_e is high during LINE2.
        pulse_refresh(rp);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #2;
            if (per >= rp + 128 && lcd_e) break;
        end
        check("pre_rst_e", 64'(lcd_e), 64'(1));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        check("rst_drop_e", 64'(lcd_e), 64'(0));
        check("rst_busy2", 64'(busy), 64'(1));
        @(negedge clk);
        rst = 1'b0;
        log_q.delete();
        wait_idle("reinit_idle", 200, ip);
        check("reinit_fall", 64'(ip), 64'(43));
        check("reinit_count", 64'(log_q.size()), 64'(4));
        check("reinit_rise0", 64'(log_per(0)), 64'(12));
        check("reinit_cmd0", 64'(log_at(0)), 64'(9'h038));
        check("reinit_cmd3", 64'(log_at(3)), 64'(9'h001));

        repeat (5) @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
